known_sink_update: RTL
======================

// Module: known_sink_update
// PURPOSE
//  Upstream producer of the knownSinks table in shared data memory. On start, reads knownSinkCount,
//  scans knownSinks[] for sink_id; if absent, appends it and writes back count+1. The neighbour-sink /
//  cluster check stage downstream then reads this table to decide the forAggregation flag.
//  Shares the word-addressed (stride 2) memory port: address/wr_en/data_out out, data_in back.
// PARAMETERS
//  WORD_WIDTH     16       data/address width
//  MAX_SINKS      32       knownSinks capacity (region 0x0008..0x0046)
//  KS_BASE        16'h0008 address of knownSinks[0]; entry j at KS_BASE+2*j
//  KS_COUNT_ADDR  16'h0688 address of knownSinkCount
// PORTS
//  clock     in   1   single clock, rising edge
//  nrst      in   1   asynchronous, active-low reset
//  en        in   1   re-arm: leave WAIT_EN, clear result flags
//  start     in   1   begin update; sampled only in IDLE
//  sink_id   in   16  sink to record; latched on accepted start
//  data_in   in   16  memory read data, valid 1 cycle after address
//  address   out  16  memory address (registered)
//  wr_en     out  1   memory write strobe, one cycle per write
//  data_out  out  16  memory write data (registered)
//  duplicate out  1   sink_id already present; held until re-armed by en
//  overflow  out  1   table full, sink_id dropped; held until re-armed by en
//  done      out  1   operation complete; held until re-armed by en
// BEHAVIOUR
//  Reset (async): address=KS_COUNT_ADDR, wr_en=0, data_out=0, duplicate=0, overflow=0, done=0,
//   j=0, replace pointer=0, state=WAIT_EN. Reset mid-operation aborts at once. If the ID is written but the
//   count is not, the entry stays invisible (count not bumped).
//  WAIT_EN: en=1 -> clear done/duplicate/overflow/wr_en, address=KS_COUNT_ADDR -> IDLE. start is ignored here.
//  IDLE: start=1 -> id_q<=sink_id, address=KS_COUNT_ADDR -> RD_CNT. en is ignored outside WAIT_EN.
//  RD_CNT: cnt_q<=data_in; a value above MAX_SINKS is treated as MAX_SINKS (full).
//   If cnt_q==0 -> APPEND. Otherwise j=0, address=KS_BASE -> CMP.
//  CMP (one entry per cycle): data_in==id_q -> duplicate=1 -> DONE.
//   Else j=j+1. If j==cnt_q -> APPEND. Otherwise address=KS_BASE+2*j and stay in CMP.
//  APPEND: cnt_q<MAX_SINKS -> address=KS_BASE+2*cnt_q, data_out=id_q, wr_en=1 -> WR_CNT.
//   Full -> overflow=1, no write -> DONE. (Replace behaviour differs; see CONFIGURATION.)
//  WR_CNT: address=KS_COUNT_ADDR, data_out=cnt_q+1 (WORD_WIDTH, no wrap possible), wr_en=1 -> DONE.
//  DONE: wr_en=0, done=1 -> WAIT_EN. Exactly one of {append, duplicate, overflow} per operation.
//  Latency, start to done, with scan length k = cnt_q (or match index+1): 2+k+1 cycles for duplicate;
//   2+k+3 cycles for append.
//  Addresses are always even. Writes never target outside KS_BASE..KS_BASE+2*(MAX_SINKS-1) or KS_COUNT_ADDR.
// CONFIGURATION
//  KSU_FIFO_REPLACE_EN defined: a full table overwrites knownSinks[rp] with id_q
//   (address KS_BASE+2*rp, one write). Then rp=(rp==MAX_SINKS-1)?0:rp+1.
//   Count is not rewritten and overflow=1 still flags the eviction. rp is cleared only by reset.
//  Not defined: full table -> overflow=1, no memory write; rp logic absent.
// TESTING
//  1 count@0x0688=0, start, sink_id=0x0005 -> write 0x0005@0x0008, then 0x0001@0x0688; done=1, dup=0, ovf=0.
//  2 table {3,5,9}, count=3, sink_id=5 -> reads 0x0688,0x0008,0x000A only; duplicate=1; wr_en never high.
//  3 same table, sink_id=7 -> write 0x0007@0x000E, then 0x0004@0x0688; done=1.
//  4 count=32, no match, sink_id=0x00AA -> macro off: overflow=1, no write. Macro on: write 0x00AA@0x0008;
//    a 2nd overflow writes @0x000A; count stays 32.
//  5 nrst low during CMP -> all outputs at reset values immediately, no write. Then en, start -> normal run.
//  6 start pulsed while in WAIT_EN without en -> ignored; done stays 0 and no memory access.

Source files
------------

// File: rtl/known_sink_update.sv
// known_sink_update: records sink_id in the shared knownSinks table, appending it and bumping the count if absent.
// Optional build macro KSU_FIFO_REPLACE_EN: a full table overwrites the oldest slot round-robin instead of dropping.
module known_sink_update #(
  parameter int                    WORD_WIDTH    = 16,
  parameter int                    MAX_SINKS     = 32,
  parameter logic [WORD_WIDTH-1:0] KS_BASE       = 16'h0008,
  parameter logic [WORD_WIDTH-1:0] KS_COUNT_ADDR = 16'h0688
) (
  input  logic                  i_clock,
  input  logic                  i_nrst,
  input  logic                  i_en,
  input  logic                  i_start,
  input  logic [WORD_WIDTH-1:0] i_sink_id,
  input  logic [WORD_WIDTH-1:0] i_data_in,
  output logic [WORD_WIDTH-1:0] o_address,
  output logic                  o_wr_en,
  output logic [WORD_WIDTH-1:0] o_data_out,
  output logic                  o_duplicate,
  output logic                  o_overflow,
  output logic                  o_done
);

  localparam logic [WORD_WIDTH-1:0] MAX_W = WORD_WIDTH'(MAX_SINKS);

  typedef enum logic [2:0] {
    S_WAIT_EN, S_IDLE, S_RD_CNT, S_CMP, S_APPEND, S_WR_CNT, S_DONE
  } state_t;

  state_t                r_state, w_state;
  logic [WORD_WIDTH-1:0] r_id, w_id;
  logic [WORD_WIDTH-1:0] r_cnt, w_cnt;
  logic [WORD_WIDTH-1:0] r_j, w_j;
  logic [WORD_WIDTH-1:0] r_address, w_address;
  logic [WORD_WIDTH-1:0] r_dataOut, w_dataOut;
  logic                  r_wrEn, w_wrEn;
  logic                  r_duplicate, w_duplicate;
  logic                  r_overflow, w_overflow;
  logic                  r_done, w_done;
  logic [WORD_WIDTH-1:0] w_cntClamped;
  logic [WORD_WIDTH-1:0] w_jNext;

`ifdef KSU_FIFO_REPLACE_EN
  localparam int RP_W = $clog2(MAX_SINKS);
  logic [RP_W-1:0] r_rp, w_rp;
`endif

  // A corrupt count above capacity is treated as a full table.
  assign w_cntClamped = (i_data_in > MAX_W) ? MAX_W : i_data_in;
  assign w_jNext      = r_j + WORD_WIDTH'(1);

  always_comb begin
    w_state     = r_state;
    w_id        = r_id;
    w_cnt       = r_cnt;
    w_j         = r_j;
    w_address   = r_address;
    w_dataOut   = r_dataOut;
    w_wrEn      = r_wrEn;
    w_duplicate = r_duplicate;
    w_overflow  = r_overflow;
    w_done      = r_done;
`ifdef KSU_FIFO_REPLACE_EN
    w_rp        = r_rp;
`endif
    case (r_state)
      S_WAIT_EN: begin
        if (i_en) begin
          w_done      = 1'b0;
          w_duplicate = 1'b0;
          w_overflow  = 1'b0;
          w_wrEn      = 1'b0;
          w_address   = KS_COUNT_ADDR;
          w_state     = S_IDLE;
        end
      end
      S_IDLE: begin
        if (i_start) begin
          w_id      = i_sink_id;
          w_address = KS_COUNT_ADDR;
          w_state   = S_RD_CNT;
        end
      end
      S_RD_CNT: begin
        w_cnt = w_cntClamped;
        if (w_cntClamped == '0) begin
          w_state = S_APPEND;
        end else begin
          w_j       = '0;
          w_address = KS_BASE;
          w_state   = S_CMP;
        end
      end
      // data_in holds entry r_j; the address for entry r_j+1 is issued in the same cycle.
      S_CMP: begin
        if (i_data_in == r_id) begin
          w_duplicate = 1'b1;
          w_state     = S_DONE;
        end else begin
          w_j = w_jNext;
          if (w_jNext == r_cnt) begin
            w_state = S_APPEND;
          end else begin
            w_address = KS_BASE + (w_jNext << 1);
          end
        end
      end
      S_APPEND: begin
        if (r_cnt < MAX_W) begin
          w_address = KS_BASE + (r_cnt << 1);
          w_dataOut = r_id;
          w_wrEn    = 1'b1;
          w_state   = S_WR_CNT;
        end else begin
          w_overflow = 1'b1;
`ifdef KSU_FIFO_REPLACE_EN
          w_address  = KS_BASE + WORD_WIDTH'({r_rp, 1'b0});
          w_dataOut  = r_id;
          w_wrEn     = 1'b1;
          w_rp       = (r_rp == RP_W'(MAX_SINKS - 1)) ? '0 : r_rp + RP_W'(1);
`endif
          w_state    = S_DONE;
        end
      end
      S_WR_CNT: begin
        w_address = KS_COUNT_ADDR;
        w_dataOut = r_cnt + WORD_WIDTH'(1);
        w_wrEn    = 1'b1;
        w_state   = S_DONE;
      end
      S_DONE: begin
        w_wrEn  = 1'b0;
        w_done  = 1'b1;
        w_state = S_WAIT_EN;
      end
      default: w_state = S_WAIT_EN;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state     <= S_WAIT_EN;
      r_id        <= '0;
      r_cnt       <= '0;
      r_j         <= '0;
      r_address   <= KS_COUNT_ADDR;
      r_dataOut   <= '0;
      r_wrEn      <= 1'b0;
      r_duplicate <= 1'b0;
      r_overflow  <= 1'b0;
      r_done      <= 1'b0;
`ifdef KSU_FIFO_REPLACE_EN
      r_rp        <= '0;
`endif
    end else begin
      r_state     <= w_state;
      r_id        <= w_id;
      r_cnt       <= w_cnt;
      r_j         <= w_j;
      r_address   <= w_address;
      r_dataOut   <= w_dataOut;
      r_wrEn      <= w_wrEn;
      r_duplicate <= w_duplicate;
      r_overflow  <= w_overflow;
      r_done      <= w_done;
`ifdef KSU_FIFO_REPLACE_EN
      r_rp        <= w_rp;
`endif
    end
  end

  assign o_address   = r_address;
  assign o_wr_en     = r_wrEn;
  assign o_data_out  = r_dataOut;
  assign o_duplicate = r_duplicate;
  assign o_overflow  = r_overflow;
  assign o_done      = r_done;

endmodule
